// File: rtl/comp_arch_pkg.sv
// Shared types and defaults for the comp_arch_basics_unit datapath slice.
// Shift direction encoding matches the raw right_shift control bit.
package comp_arch_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic {
        SHIFT_LEFT  = 1'b0,
        SHIFT_RIGHT = 1'b1
    } shift_dir_t;

endpackage : comp_arch_pkg

// File: rtl/comp_arch_basics_unit_if.sv
// Signal bundle for comp_arch_basics_unit: NAND operands, shifter controls and results.
// The master side drives operands; the slave side (the unit) returns results.
interface comp_arch_basics_unit_if #(
    parameter int WIDTH = 4
);

    logic             a;
    logic             b;
    logic             right_shift;
    logic [WIDTH-1:0] four_in;
    logic             nand_out;
    logic [WIDTH-1:0] four_out;
    logic [WIDTH-1:0] four_shifted;

    modport master (
        output a,
        output b,
        output right_shift,
        output four_in,
        input  nand_out,
        input  four_out,
        input  four_shifted
    );

    modport slave (
        input  a,
        input  b,
        input  right_shift,
        input  four_in,
        output nand_out,
        output four_out,
        output four_shifted
    );

endinterface : comp_arch_basics_unit_if

// File: rtl/shift_stage.sv
// Combinational single-position logical shifter; the vacated bit is zero-filled
// and the bit shifted out is dropped.
module shift_stage
    import comp_arch_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] data,
    input  shift_dir_t       dir,
    output logic [WIDTH-1:0] shifted
);

    always_comb begin
        shifted = '0;
        case (dir)
            SHIFT_RIGHT: shifted = {1'b0, data[WIDTH-1:1]};
            SHIFT_LEFT:  shifted = {data[WIDTH-2:0], 1'b0};
            default:     shifted = '0;
        endcase
    end

endmodule : shift_stage

// File: rtl/comp_arch_basics_unit.sv
// Step-1 datapath primitive: combinational NAND, a registered copy of four_in and
// a registered one-position shift of four_in, both cleared by async active-low reset.
module comp_arch_basics_unit
    import comp_arch_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    comp_arch_basics_unit_if.slave  bus
);

    logic [WIDTH-1:0] shifted_w;
    logic [WIDTH-1:0] four_out_d;
    logic [WIDTH-1:0] four_out_q;
    logic [WIDTH-1:0] four_shifted_d;
    logic [WIDTH-1:0] four_shifted_q;

    assign bus.nand_out = ~(bus.a & bus.b);

    // Shifter always sources the live input word, so nothing recirculates.
    shift_stage #(
        .WIDTH (WIDTH)
    ) u_shift_stage (
        .data    (bus.four_in),
        .dir     (shift_dir_t'(bus.right_shift)),
        .shifted (shifted_w)
    );

    always_comb begin
        four_out_d     = bus.four_in;
        four_shifted_d = shifted_w;
    end

    // Register stage: capture copy and shifted word on the same edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            four_out_q     <= '0;
            four_shifted_q <= '0;
        end else begin
            four_out_q     <= four_out_d;
            four_shifted_q <= four_shifted_d;
        end
    end

    assign bus.four_out     = four_out_q;
    assign bus.four_shifted = four_shifted_q;

endmodule : comp_arch_basics_unit

// File: tb/tb_comp_arch_basics_unit.sv
// Self-checking bench for comp_arch_basics_unit: vector table plus scoreboard queue,
// with hand-written sequences for reset and no-accumulation corner cases.
module tb_comp_arch_basics_unit;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] din;
        logic         rs;
        logic [W-1:0] exp_out;
        logic [W-1:0] exp_sh;
    } vec_t;

    typedef struct {
        logic [W-1:0] o;
        logic [W-1:0] s;
    } exp_t;

    logic   clock;
    logic   reset;
    int     tests;
    int     fails;
    exp_t   sb[$];
    vec_t   vecs[6];

    comp_arch_basics_unit_if #(.WIDTH(W)) bus ();

    comp_arch_basics_unit #(
        .WIDTH (W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] model_shift(input logic [W-1:0] d, input logic rs);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            if (rs) begin
                if (i < W - 1) r[i] = d[i+1];
            end else begin
                if (i > 0) r[i] = d[i-1];
            end
        end
        return r;
    endfunction

    // Drive between edges, queue the expectation, then compare just after the edge.
    task automatic apply(input string name, input logic [W-1:0] din, input logic rs,
                         input logic [W-1:0] eo, input logic [W-1:0] es);
        exp_t e;
        @(negedge clock);
        bus.four_in     = din;
        bus.right_shift = rs;
        e.o = eo;
        e.s = es;
        sb.push_back(e);
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: got empty scoreboard, want one entry", name);
        end else begin
            e = sb.pop_front();
            check({name, ".four_out"}, bus.four_out, e.o);
            check({name, ".four_shifted"}, bus.four_shifted, e.s);
        end
    endtask

    initial begin
        logic [W-1:0] rd;
        logic         rr;
        logic [1:0]   ab;
        tests = 0;
        fails = 0;

        vecs[0] = '{din: 4'b0101, rs: 1'b0, exp_out: 4'b0101, exp_sh: 4'b1010};
        vecs[1] = '{din: 4'b0011, rs: 1'b0, exp_out: 4'b0011, exp_sh: 4'b0110};
        vecs[2] = '{din: 4'b0001, rs: 1'b0, exp_out: 4'b0001, exp_sh: 4'b0010};
        vecs[3] = '{din: 4'b1010, rs: 1'b1, exp_out: 4'b1010, exp_sh: 4'b0101};
        vecs[4] = '{din: 4'b1100, rs: 1'b1, exp_out: 4'b1100, exp_sh: 4'b0110};
        vecs[5] = '{din: 4'b1111, rs: 1'b1, exp_out: 4'b1111, exp_sh: 4'b0111};

        reset           = 1'b0;
        bus.a           = 1'b0;
        bus.b           = 1'b0;
        bus.right_shift = 1'b0;
        bus.four_in     = 4'b1111;

        // NAND truth table, all within one half period with no rising edge.
        @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            ab    = 2'(i);
            bus.a = ab[1];
            bus.b = ab[0];
            #1;
            check($sformatf("nand_%0d%0d", ab[1], ab[0]), {3'b000, bus.nand_out},
                  {3'b000, (i == 3) ? 1'b0 : 1'b1});
        end

        // Held in reset with clock running.
        repeat (3) @(posedge clock);
        #1;
        check("reset.four_out", bus.four_out, 4'b0000);
        check("reset.four_shifted", bus.four_shifted, 4'b0000);

        @(negedge clock);
        reset = 1'b1;
        #1;
        check("release.four_out_pre_edge", bus.four_out, 4'b0000);
        apply("release", 4'b1111, 1'b0, 4'b1111, 4'b1110);

        for (int i = 0; i < 6; i++) begin
            apply($sformatf("vec%0d", i), vecs[i].din, vecs[i].rs, vecs[i].exp_out, vecs[i].exp_sh);
        end

        apply("zero_left", 4'b0000, 1'b0, 4'b0000, 4'b0000);
        apply("zero_right", 4'b0000, 1'b1, 4'b0000, 4'b0000);
        apply("ones_left", 4'b1111, 1'b0, 4'b1111, 4'b1110);

        // Asynchronous reset asserted mid-period clears without an edge.
        apply("pre_midreset", 4'b1111, 1'b1, 4'b1111, 4'b0111);
        #2;
        reset = 1'b0;
        #1;
        check("midreset.four_out", bus.four_out, 4'b0000);
        check("midreset.four_shifted", bus.four_shifted, 4'b0000);
        repeat (2) @(posedge clock);
        #1;
        check("midreset_hold.four_out", bus.four_out, 4'b0000);
        check("midreset_hold.four_shifted", bus.four_shifted, 4'b0000);
        @(negedge clock);
        reset = 1'b1;

        // Constant input must not accumulate shifts across edges.
        for (int i = 0; i < 3; i++) begin
            apply($sformatf("hold%0d", i), 4'b1000, 1'b1, 4'b1000, 4'b0100);
        end
        apply("hold_flip", 4'b1000, 1'b0, 4'b1000, 4'b0000);

        for (int i = 0; i < 8; i++) begin
            rd = 4'($urandom_range(0, 15));
            rr = 1'($urandom_range(0, 1));
            apply($sformatf("rand%0d", i), rd, rr, rd, model_shift(rd, rr));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_comp_arch_basics_unit
